// File: rtl/wired_bpu_resolve_pkg.sv
// Shared branch-predictor types plus the resolve-stage queue entry.
// wired0_defines holds the types shared across the BPU; wired_bpu_resolve_pkg
// holds only what is private to the resolve stage.
package wired0_defines;

  typedef enum logic [1:0] {
    BPU_TARGET_NPC    = 2'd0,
    BPU_TARGET_CALL   = 2'd1,
    BPU_TARGET_RETURN = 2'd2,
    BPU_TARGET_IMM    = 2'd3
  } bpu_target_type_e;

  typedef struct packed {
    logic [31:0]      predict_pc;
    logic [4:0]       history;
    logic [1:0]       lphr;
    logic [2:0]       ras_ptr;
    bpu_target_type_e target_type;
    logic             dir_type;
    logic             tid;
  } bpu_predict_t;

  typedef struct packed {
    logic             redirect;
    logic             miss;
    logic             ras_miss_type;
    logic             need_update;
    logic [31:0]      pc;
    logic [31:0]      true_target;
    logic [31:0]      btb_target;
    logic             true_taken;
    bpu_target_type_e true_target_type;
    logic             true_conditional_jmp;
    logic [4:0]       history;
    logic [1:0]       lphr;
    logic [2:0]       ras_ptr;
    logic             tid;
  } bpu_correct_t;

endpackage

package wired_bpu_resolve_pkg;
  import wired0_defines::*;

  // Resolve entry with direction/target verdicts precomputed at acceptance,
  // so the pop side only has to format the feedback.
  typedef struct packed {
    logic [31:0]      pc;
    logic             taken;
    logic [31:0]      target;
    bpu_target_type_e target_type;
    logic             conditional;
    logic [31:0]      true_npc;
    logic             miss;
    logic             type_miss;
    logic [4:0]       history;
    logic [1:0]       lphr;
    logic [2:0]       ras_ptr;
    logic             tid;
  } rsv_entry_t;

  localparam int ENTRY_W = $bits(rsv_entry_t);

  // Return-stack pointer as it stands after the resolved branch executes.
  function automatic logic [2:0] ras_adjust(input logic [2:0] ptr,
                                            input bpu_target_type_e t);
    logic [2:0] r;
    r = ptr;
    if (t == BPU_TARGET_CALL)   r = ptr + 3'd1;
    if (t == BPU_TARGET_RETURN) r = ptr - 3'd1;
    return r;
  endfunction

endpackage

// File: rtl/wired_resolve_fifo.sv
// Parametric synchronous FIFO; head entry is read straight from the
// storage registers so it is available the cycle after the push.
module wired_resolve_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));

  // Pointer and occupancy bookkeeping; a simultaneous push and pop nets zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wired_bpu_resolve.sv
// Branch resolve stage: queues backend resolves, compares them against the
// prediction they carried and feeds corrections back to the PC generator.
// A 1-bit thread id marks the current speculation epoch; every redirect
// flips it so anything fetched on the wrong path is purged.
module wired_bpu_resolve
  import wired0_defines::*;
  import wired_bpu_resolve_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r_valid_i,
  output logic             r_ready_o,
  input  logic [31:0]      r_pc_i,
  input  bpu_predict_t     r_predict_i,
  input  logic             r_taken_i,
  input  logic [31:0]      r_target_i,
  input  bpu_target_type_e r_target_type_i,
  input  logic             r_conditional_i,
  output bpu_correct_t     p_correct_o,
  output logic [31:0]      perf_branch_o,
  output logic [31:0]      perf_miss_o
);

  logic         cur_tid;
  logic         fifo_empty;
  logic         fifo_full;
  logic         push;
  logic         pop;
  logic         live_pop;
  logic         redirect;
  rsv_entry_t   in_entry;
  rsv_entry_t   head;
  bpu_correct_t correct_d;

  assign r_ready_o = !fifo_full;
  // Resolves from a dead epoch are accepted but silently dropped.
  assign push      = r_valid_i && r_ready_o && (r_predict_i.tid == cur_tid);
  assign pop       = !fifo_empty;
  assign live_pop  = pop && (head.tid == cur_tid);
  assign redirect  = live_pop && head.miss;

  // Build the queue entry and its verdicts from the incoming resolve.
  always_comb begin
    logic [31:0] npc;
    npc      = r_taken_i ? r_target_i : (r_pc_i + 32'd4);
    in_entry = '0;
    in_entry.pc          = r_pc_i;
    in_entry.taken       = r_taken_i;
    in_entry.target      = r_target_i;
    in_entry.target_type = r_target_type_i;
    in_entry.conditional = r_conditional_i;
    in_entry.true_npc    = npc;
    in_entry.miss        = (npc != r_predict_i.predict_pc);
    in_entry.type_miss   = (r_target_type_i != r_predict_i.target_type) ||
                           (r_conditional_i != r_predict_i.dir_type);
    in_entry.history     = r_predict_i.history;
    in_entry.lphr        = r_predict_i.lphr;
    in_entry.ras_ptr     = r_predict_i.ras_ptr;
    in_entry.tid         = r_predict_i.tid;
  end

  wired_resolve_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Format the correction for a live head; all-zero when nothing live pops.
  always_comb begin
    correct_d = '0;
    if (live_pop) begin
      correct_d.redirect             = head.miss;
      correct_d.miss                 = head.miss;
      correct_d.ras_miss_type        = head.type_miss;
      correct_d.need_update          = head.miss || head.type_miss || head.conditional;
      correct_d.pc                   = head.pc;
      correct_d.true_target          = head.true_npc;
      correct_d.btb_target           = head.target;
      correct_d.true_taken           = head.taken;
      correct_d.true_target_type     = head.target_type;
      correct_d.true_conditional_jmp = head.conditional;
      correct_d.history              = head.history;
      correct_d.lphr                 = head.lphr;
      correct_d.ras_ptr              = ras_adjust(head.ras_ptr, head.target_type);
      correct_d.tid                  = head.miss ? ~cur_tid : cur_tid;
    end
  end

  // Register feedback, flip the epoch on redirect and count events.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_correct_o   <= '0;
      cur_tid       <= 1'b0;
      perf_branch_o <= '0;
      perf_miss_o   <= '0;
    end else begin
      p_correct_o <= correct_d;
      if (redirect) cur_tid       <= ~cur_tid;
      if (live_pop) perf_branch_o <= perf_branch_o + 32'd1;
      if (redirect) perf_miss_o   <= perf_miss_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_wired_bpu_resolve.sv
// Bench for wired_bpu_resolve: directed scenarios with literal expectations
// followed by randomized traffic against a queue-based reference model.
module tb_wired_bpu_resolve;
  import wired0_defines::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             r_valid_i;
  logic             r_ready_o;
  logic [31:0]      r_pc_i;
  bpu_predict_t     r_predict_i;
  logic             r_taken_i;
  logic [31:0]      r_target_i;
  bpu_target_type_e r_target_type_i;
  logic             r_conditional_i;
  bpu_correct_t     p_correct_o;
  logic [31:0]      perf_branch_o;
  logic [31:0]      perf_miss_o;

  wired_bpu_resolve #(.FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .r_valid_i       (r_valid_i),
    .r_ready_o       (r_ready_o),
    .r_pc_i          (r_pc_i),
    .r_predict_i     (r_predict_i),
    .r_taken_i       (r_taken_i),
    .r_target_i      (r_target_i),
    .r_target_type_i (r_target_type_i),
    .r_conditional_i (r_conditional_i),
    .p_correct_o     (p_correct_o),
    .perf_branch_o   (perf_branch_o),
    .perf_miss_o     (perf_miss_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    bpu_predict_t     pr;
    logic             taken;
    logic [31:0]      target;
    bpu_target_type_e tt;
    logic             cond;
  } res_t;

  res_t         mq[$];
  logic         m_tid;
  bpu_correct_t m_exp;
  logic [31:0]  m_branch;
  logic [31:0]  m_miss;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // What the PC generator must be told about a resolved branch.
  function automatic bpu_correct_t expect_of(input res_t e);
    bpu_correct_t c;
    logic [31:0]  real_next;
    int           rp;
    real_next = e.taken ? e.target : e.pc + 32'd4;
    rp = int'(e.pr.ras_ptr);
    if (e.tt == BPU_TARGET_CALL)   rp = rp + 1;
    if (e.tt == BPU_TARGET_RETURN) rp = rp + 7;
    c = '0;
    c.miss                 = (real_next != e.pr.predict_pc);
    c.redirect             = c.miss;
    c.ras_miss_type        = (e.tt != e.pr.target_type) || (e.cond != e.pr.dir_type);
    c.need_update          = c.miss || c.ras_miss_type || e.cond;
    c.pc                   = e.pc;
    c.true_target          = real_next;
    c.btb_target           = e.target;
    c.true_taken           = e.taken;
    c.true_target_type     = e.tt;
    c.true_conditional_jmp = e.cond;
    c.history              = e.pr.history;
    c.lphr                 = e.pr.lphr;
    c.ras_ptr              = 3'(rp % 8);
    return c;
  endfunction

  // One clock: check ready, advance the model across the edge, check outputs.
  task automatic step();
    bit           rdy_exp;
    res_t         e;
    res_t         n;
    bpu_correct_t nxt;
    logic         ntid;
    #1;
    rdy_exp = (mq.size() < DEPTH);
    chk("ready", 128'(r_ready_o), 128'(rdy_exp));
    nxt  = '0;
    ntid = m_tid;
    if (!rst_n) begin
      mq.delete();
      ntid     = 1'b0;
      m_branch = '0;
      m_miss   = '0;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.pr.tid == m_tid) begin
          nxt = expect_of(e);
          m_branch = m_branch + 32'd1;
          if (nxt.redirect) begin
            ntid   = ~m_tid;
            m_miss = m_miss + 32'd1;
          end
          nxt.tid = ntid;
        end
      end
      if (r_valid_i && rdy_exp && (r_predict_i.tid == m_tid)) begin
        n.pc = r_pc_i; n.pr = r_predict_i; n.taken = r_taken_i;
        n.target = r_target_i; n.tt = r_target_type_i; n.cond = r_conditional_i;
        mq.push_back(n);
      end
    end
    m_tid = ntid;
    m_exp = nxt;
    @(posedge clk);
    #1;
    chk("p_correct", 128'(p_correct_o), 128'(m_exp));
    chk("perf_branch", 128'(perf_branch_o), 128'(m_branch));
    chk("perf_miss", 128'(perf_miss_o), 128'(m_miss));
    @(negedge clk);
  endtask

  task automatic set_idle();
    r_valid_i       = 1'b0;
    r_pc_i          = '0;
    r_predict_i     = '0;
    r_taken_i       = 1'b0;
    r_target_i      = '0;
    r_target_type_i = BPU_TARGET_NPC;
    r_conditional_i = 1'b0;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic [31:0] ppc, input logic taken,
                         input logic [31:0] tgt, input bpu_target_type_e tt,
                         input bpu_target_type_e ptt, input logic cond, input logic pdir,
                         input logic [2:0] ras, input logic tid);
    r_valid_i                 = 1'b1;
    r_pc_i                    = pc;
    r_taken_i                 = taken;
    r_target_i                = tgt;
    r_target_type_i           = tt;
    r_conditional_i           = cond;
    r_predict_i               = '0;
    r_predict_i.predict_pc    = ppc;
    r_predict_i.history       = 5'h15;
    r_predict_i.lphr          = 2'd2;
    r_predict_i.ras_ptr       = ras;
    r_predict_i.target_type   = ptt;
    r_predict_i.dir_type      = pdir;
    r_predict_i.tid           = tid;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    m_tid = 1'b0; m_exp = '0; m_branch = '0; m_miss = '0;
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();
    chk("reset_out", 128'(p_correct_o), 128'(0));
    chk("reset_ready", 128'(r_ready_o), 128'(1));
    chk("reset_perf", 128'(perf_branch_o), 128'(0));

    // Correctly predicted not-taken conditional.
    set_res(32'h1c000010, 32'h1c000014, 1'b0, 32'h1c000200, BPU_TARGET_IMM,
            BPU_TARGET_IMM, 1'b1, 1'b1, 3'd3, 1'b0);
    step();
    set_idle();
    step();
    chk("nt_redirect", 128'(p_correct_o.redirect), 128'(0));
    chk("nt_need_update", 128'(p_correct_o.need_update), 128'(1));
    chk("nt_true_target", 128'(p_correct_o.true_target), 128'(32'h1c000014));
    chk("nt_tid", 128'(p_correct_o.tid), 128'(0));

    // Taken branch predicted fall-through: redirect and epoch flip.
    set_res(32'h1c000020, 32'h1c000024, 1'b1, 32'h1c000100, BPU_TARGET_IMM,
            BPU_TARGET_IMM, 1'b1, 1'b1, 3'd0, 1'b0);
    step();
    set_idle();
    step();
    chk("mp_redirect", 128'(p_correct_o.redirect), 128'(1));
    chk("mp_true_target", 128'(p_correct_o.true_target), 128'(32'h1c000100));
    chk("mp_tid", 128'(p_correct_o.tid), 128'(1));
    chk("mp_perf_miss", 128'(perf_miss_o), 128'(1));
    chk("mp_perf_branch", 128'(perf_branch_o), 128'(2));
    step();
    chk("mp_pulse", 128'(p_correct_o), 128'(0));

    // Return-stack pointer wrap for CALL (epoch now 1) and RETURN.
    set_res(32'h1c000040, 32'h1c000044, 1'b1, 32'h1c000400, BPU_TARGET_CALL,
            BPU_TARGET_NPC, 1'b0, 1'b0, 3'd7, 1'b1);
    step();
    set_idle();
    step();
    chk("call_ras", 128'(p_correct_o.ras_ptr), 128'(0));
    chk("call_redirect", 128'(p_correct_o.redirect), 128'(1));
    chk("call_tid", 128'(p_correct_o.tid), 128'(0));
    set_res(32'h1c000050, 32'h1c000080, 1'b1, 32'h1c000080, BPU_TARGET_RETURN,
            BPU_TARGET_RETURN, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    set_idle();
    step();
    chk("ret_ras", 128'(p_correct_o.ras_ptr), 128'(7));
    chk("ret_redirect", 128'(p_correct_o.redirect), 128'(0));
    chk("ret_need_update", 128'(p_correct_o.need_update), 128'(0));

    // Back-to-back epoch-0 resolves, first mispredicts: the rest are purged.
    do_reset();
    set_res(32'h1c000020, 32'h1c000024, 1'b1, 32'h1c000100, BPU_TARGET_IMM,
            BPU_TARGET_IMM, 1'b1, 1'b1, 3'd0, 1'b0);
    step();
    set_res(32'h1c000100, 32'h1c000104, 1'b0, 32'h1c000300, BPU_TARGET_IMM,
            BPU_TARGET_IMM, 1'b1, 1'b1, 3'd0, 1'b0);
    step();
    chk("purge_redirect", 128'(p_correct_o.redirect), 128'(1));
    set_res(32'h1c000104, 32'h1c000108, 1'b0, 32'h1c000300, BPU_TARGET_IMM,
            BPU_TARGET_IMM, 1'b1, 1'b1, 3'd0, 1'b0);
    step();
    chk("purge_zero1", 128'(p_correct_o), 128'(0));
    set_idle();
    step();
    chk("purge_zero2", 128'(p_correct_o), 128'(0));
    chk("purge_perf_miss", 128'(perf_miss_o), 128'(1));
    chk("purge_perf_branch", 128'(perf_branch_o), 128'(1));

    // Reset in the middle of a stream of resolves.
    for (int i = 0; i < 3; i++) begin
      set_res(32'h1c001000 + 32'(i * 4), 32'h1c001004 + 32'(i * 4), 1'b0, 32'h0,
              BPU_TARGET_NPC, BPU_TARGET_NPC, 1'b0, 1'b0, 3'd1, 1'b1);
      step();
    end
    rst_n = 1'b0;
    step();
    chk("rst_mid_out", 128'(p_correct_o), 128'(0));
    chk("rst_mid_perf", 128'(perf_branch_o), 128'(0));
    rst_n = 1'b1;
    set_idle();
    step();
    chk("rst_mid_quiet", 128'(p_correct_o), 128'(0));
    set_res(32'h1c002000, 32'h1c002004, 1'b0, 32'h0, BPU_TARGET_NPC,
            BPU_TARGET_NPC, 1'b0, 1'b0, 3'd2, 1'b0);
    step();
    set_idle();
    step();
    chk("rst_mid_tid", 128'(p_correct_o.tid), 128'(0));
    chk("rst_mid_live", 128'(perf_branch_o), 128'(1));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        tk;
      logic [31:0] ppc;
      bpu_target_type_e tt;
      bpu_target_type_e ptt;
      logic        cond;
      logic        pdir;
      logic        tid;
      rst_n = ($urandom_range(0, 199) != 0);
      pc   = $urandom & 32'hfffffffc;
      if ($urandom_range(0, 19) == 0) pc = 32'hfffffffc;
      tgt  = $urandom & 32'hfffffffc;
      tk   = 1'($urandom_range(0, 1));
      ppc  = ($urandom_range(0, 9) < 6) ? (tk ? tgt : pc + 32'd4) : ($urandom & 32'hfffffffc);
      tt   = bpu_target_type_e'($urandom_range(0, 3));
      ptt  = ($urandom_range(0, 9) < 8) ? tt : bpu_target_type_e'($urandom_range(0, 3));
      cond = 1'($urandom_range(0, 1));
      pdir = ($urandom_range(0, 9) < 8) ? cond : 1'($urandom_range(0, 1));
      tid  = ($urandom_range(0, 9) < 8) ? m_tid : ~m_tid;
      if ($urandom_range(0, 9) < 7) begin
        set_res(pc, ppc, tk, tgt, tt, ptt, cond, pdir, 3'($urandom_range(0, 7)), tid);
        r_predict_i.history = 5'($urandom);
        r_predict_i.lphr    = 2'($urandom);
      end else begin
        set_idle();
      end
      step();
    end
    rst_n = 1'b1;
    set_idle();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
